tluh_device_adapter: RTL and testbench
======================================

// Module: tluh_device_adapter
// PURPOSE
//  Device-side (responder) end of the TL-UH link. Accepts channel A requests from the crossbar or a
//  host adapter and turns them into a simple req/gnt/rvalid memory-port sequence. Returns channel D
//  responses. Supports Get, PutFull/PutPartial (single-beat and burst), Intent and, optionally,
//  single-beat atomics. Placed in front of every TL-UH peripheral/memory; one transaction in flight.
// PARAMETERS
//  MAX_SIZE  4  largest accepted a_size (log2 bytes); larger sizes get an error response
// PORTS
//  clk_i       in   1          clock, all logic on rising edge
//  rst_i       in   1          asynchronous reset, active high
//  tl_d_c_a    in   h2d_t      tluh_pkg::tluh_h2d_t, channel A plus d_ready
//  tl_d_c_d    out  d2h_t      tluh_pkg::tluh_d2h_t, channel D plus a_ready
//  req_o       out  1          memory request
//  gnt_i       in   1          memory grant; the request is consumed when req_o&&gnt_i
//  we_o        out  1          1 = write
//  addr_o      out  TL_AW      word-aligned address
//  wdata_o     out  TL_DW      write data
//  be_o        out  TL_DBW     byte enables
//  rvalid_i    in   1          read data valid; arrives exactly one per granted read, >=1 cycle later
//  rdata_i     in   TL_DW      read data
//  err_i       in   1          error qualifier, sampled with rvalid_i or with write gnt_i
// BEHAVIOUR
//  Reset values: a_ready=0, d_valid=0, d_error=0, req_o=0, we_o=0, all data/addr fields 0.
//   After reset is released, FSM=IDLE and a_ready=1.
//  beats = (a_size>log2(TL_DBW)) ? 2**a_size/TL_DBW : 1. Beat address = base + n*TL_DBW, n=0..beats-1.
//  Latched at the A handshake: opcode, param, size, source, address, mask.
//  IDLE
//   a_ready=1. On a_valid:
//   - Pre-check error: a_size>MAX_SIZE, address not aligned to 2**a_size, or an atomic with
//     a_size>log2(TL_DBW). Goes to RSP with d_error=1. No memory access.
//     For Get the error response still carries `beats` beats with data 0.
//   - Get: go to RD.
//   - Put: issue write beat 0 (addr/wdata/mask taken directly from A); go to WR.
//   - Intent: go to RSP, HintAck. No memory access.
//   - Arith/Logical: go to AT_RD.
//  RD
//   req_o=1, we_o=0, be_o='1. Issue the next read only when no read is in flight and the D register
//   is empty or being drained this cycle. On rvalid_i: d_valid=1, AccessAckData, d_data=rdata_i,
//   d_error=err_i. The beat is held until d_ready. After the last beat handshakes, go to IDLE.
//  WR
//   a_ready=1 only while no write is pending. Each A beat produces one write.
//   An err_i seen with any write gnt_i sets a sticky error flag.
//   After gnt on the last beat, go to RSP: AccessAck, d_error=sticky flag.
//   A Put burst needs no further a_valid after beat 0 when beats==1.
//  AT_RD -> AT_WR -> RSP
//   Read the old value, compute new = f(old, a_data), write new under the latched mask.
//   Respond AccessAckData with d_data=old.
//   Arith params: 0 MIN, 1 MAX, 2 MINU, 3 MAXU, 4 ADD (wraps mod 2**TL_DW).
//   Logical params: 0 XOR, 1 OR, 2 AND, 3 SWAP. Other params are an error.
//   If the read returns err_i, skip the write and respond with d_error=1.
//  RSP
//   d_valid=1 until d_ready, then go to IDLE. d_source and d_size always equal the latched values.
//  Channel D output is registered. The earliest response for a single-beat Get is 2 cycles after
//   the A handshake when gnt and rvalid are immediate.
//  Back-to-back: a_ready returns to 1 in the cycle after the final D handshake.
//  Reset asserted mid-transaction aborts it immediately. Outputs return to reset values and no
//   response is sent.
// CONFIGURATION
//  TLUH_DEV_ATOMIC_EN defined: AT_RD/AT_WR are built as described above.
//  TLUH_DEV_ATOMIC_EN undefined: ArithmeticData/LogicalData get a single-beat AccessAckData with
//   d_error=1 and d_data=0. No memory access; the atomic ALU is not synthesised.
// TESTING
//  Get a_size=2 addr=0x10, mem 0x10=0xDEADBEEF -> one AccessAckData, d_data=0xDEADBEEF, source echoed
//  Get a_size=4 addr=0x40, d_ready low 3 cycles on beat1 -> 4 beats in order 0x40..0x4C, no loss or dup
//  PutPartial mask=4'b0011 data=0x1234ABCD addr=0x8 -> one write be=0011, then AccessAck d_error=0
//  Put burst a_size=3, err_i on beat0 gnt -> two writes still issued, AccessAck d_error=1
//  Arith ADD param=4, old=0xFFFFFFFF, a_data=2 -> writes 0x00000001, returns 0xFFFFFFFF
//   (with ATOMIC_EN; without ATOMIC_EN, error response)
//  Get addr=0x6 a_size=2 (misaligned), then reset mid-RD -> d_error=1, 0 mem reqs; outputs reset

Source files
------------

// File: rtl/tluh_pkg.sv
// Shared TL-UH link definitions: bus widths, channel A/D opcodes and the
// host-to-device / device-to-host channel structs used by the device adapter.
package tluh_pkg;

  localparam int TL_AW  = 32;        // address width
  localparam int TL_DW  = 32;        // data width
  localparam int TL_DBW = TL_DW / 8; // bytes per beat
  localparam int TL_SZW = 3;         // a_size / d_size width
  localparam int TL_AIW = 8;         // source id width

  // Channel A opcodes
  localparam logic [2:0] OP_PUT_FULL    = 3'h0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'h1;
  localparam logic [2:0] OP_ARITH       = 3'h2;
  localparam logic [2:0] OP_LOGICAL     = 3'h3;
  localparam logic [2:0] OP_GET         = 3'h4;
  localparam logic [2:0] OP_INTENT      = 3'h5;

  // Channel D opcodes
  localparam logic [2:0] OP_ACCESS_ACK      = 3'h0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'h1;
  localparam logic [2:0] OP_HINT_ACK        = 3'h2;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;

endpackage

// File: rtl/tluh_device_adapter.sv
// tluh_device_adapter: responder end of a TL-UH link. Converts channel A
// requests into a req/gnt/rvalid memory-port sequence and returns channel D
// responses. One transaction in flight.
//
// Optional feature macro: TLUH_DEV_ATOMIC_EN
//   defined   -> single-beat Arithmetic/Logical atomics (read-modify-write)
//   undefined -> atomics answered with an AccessAckData error, no ALU built
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   tl_d_c_a / tl_d_c_d  TL-UH channel A (+d_ready) in, channel D (+a_ready) out
//   req_o/gnt_i          memory request, consumed when req_o && gnt_i
//   we_o, addr_o, wdata_o, be_o   write enable, word address, write data, byte enables
//   rvalid_i, rdata_i    read data return, one per granted read
//   err_i                error qualifier, sampled with rvalid_i or write grant
//   state_o              current FSM state (debug)
//
// Handshake rules: a transfer on any channel happens on the rising edge where
// valid and ready are both high; valid, once raised, holds its payload stable
// until that edge. a_ready and all channel D fields are registered.
module tluh_device_adapter
  import tluh_pkg::*;
#(
  parameter int MAX_SIZE = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tluh_h2d_t         tl_d_c_a,
  output tluh_d2h_t         tl_d_c_d,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [TL_AW-1:0]  addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DBW-1:0] be_o,
  input  logic              rvalid_i,
  input  logic [TL_DW-1:0]  rdata_i,
  input  logic              err_i,
  output logic [2:0]        state_o
);

  localparam int DBW_LOG = $clog2(TL_DBW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_AT_RD = 3'd3,
    S_AT_WR = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  state_e            state_q;
  logic              a_ready_q, d_valid_q, d_error_q;
  logic [2:0]        d_opcode_q;
  logic [TL_SZW-1:0] d_size_q;
  logic [TL_AIW-1:0] d_source_q;
  logic [TL_DW-1:0]  d_data_q;
  logic [2:0]        op_q;
  logic [5:0]        beats_q, iss_cnt_q, rsp_cnt_q;
  logic              inflight_q, sticky_err_q;

  logic a_fire, d_fire, mem_fire;
  assign a_fire   = tl_d_c_a.a_valid && a_ready_q;
  assign d_fire   = d_valid_q && tl_d_c_a.d_ready;
  assign mem_fire = req_o && gnt_i;

  // Request decode on the incoming A beat
  logic             is_atomic, param_bad, pre_err;
  logic [5:0]       a_beats;
  logic [TL_AW-1:0] a_word_addr;
  logic [2:0]       err_opcode;
  always_comb begin
    is_atomic = (tl_d_c_a.a_opcode == OP_ARITH) || (tl_d_c_a.a_opcode == OP_LOGICAL);
    param_bad = ((tl_d_c_a.a_opcode == OP_ARITH)   && (tl_d_c_a.a_param > 3'd4)) ||
                ((tl_d_c_a.a_opcode == OP_LOGICAL) && (tl_d_c_a.a_param > 3'd3));
    if (int'(tl_d_c_a.a_size) > DBW_LOG)
      a_beats = 6'(1 << (int'(tl_d_c_a.a_size) - DBW_LOG));
    else
      a_beats = 6'd1;
    pre_err = (int'(tl_d_c_a.a_size) > MAX_SIZE) ||
              ((tl_d_c_a.a_address & ((TL_AW'(1) << tl_d_c_a.a_size) - TL_AW'(1))) != '0) ||
              (is_atomic && (int'(tl_d_c_a.a_size) > DBW_LOG)) ||
              (is_atomic && param_bad) ||
              (tl_d_c_a.a_opcode > OP_INTENT);
    a_word_addr = tl_d_c_a.a_address & ~TL_AW'(TL_DBW - 1);
    if (tl_d_c_a.a_opcode == OP_GET || is_atomic) err_opcode = OP_ACCESS_ACK_DATA;
    else if (tl_d_c_a.a_opcode == OP_INTENT)      err_opcode = OP_HINT_ACK;
    else                                          err_opcode = OP_ACCESS_ACK;
  end

  // A failed Get still returns every beat of its burst; other errors are one beat.
  logic rsp_last, rd_last;
  assign rsp_last = (op_q == OP_GET) ? (rsp_cnt_q == beats_q - 6'd1) : 1'b1;
  assign rd_last  = (rsp_cnt_q == beats_q - 6'd1);

`ifdef TLUH_DEV_ATOMIC_EN
  logic [2:0]        param_q;
  logic [TL_DW-1:0]  adata_q, old_q, alu_res;
  logic [TL_DBW-1:0] mask_q;
  always_comb begin
    alu_res = rdata_i;
    if (op_q == OP_ARITH) begin
      case (param_q)
        3'd0:    alu_res = ($signed(rdata_i) < $signed(adata_q)) ? rdata_i : adata_q;
        3'd1:    alu_res = ($signed(rdata_i) > $signed(adata_q)) ? rdata_i : adata_q;
        3'd2:    alu_res = (rdata_i < adata_q) ? rdata_i : adata_q;
        3'd3:    alu_res = (rdata_i > adata_q) ? rdata_i : adata_q;
        3'd4:    alu_res = rdata_i + adata_q;
        default: alu_res = rdata_i;
      endcase
    end else begin
      case (param_q)
        3'd0:    alu_res = rdata_i ^ adata_q;
        3'd1:    alu_res = rdata_i | adata_q;
        3'd2:    alu_res = rdata_i & adata_q;
        default: alu_res = adata_q;
      endcase
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      a_ready_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      d_error_q    <= 1'b0;
      d_opcode_q   <= '0;
      d_size_q     <= '0;
      d_source_q   <= '0;
      d_data_q     <= '0;
      op_q         <= '0;
      beats_q      <= '0;
      iss_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      sticky_err_q <= 1'b0;
      req_o        <= 1'b0;
      we_o         <= 1'b0;
      addr_o       <= '0;
      wdata_o      <= '0;
      be_o         <= '0;
`ifdef TLUH_DEV_ATOMIC_EN
      param_q      <= '0;
      adata_q      <= '0;
      old_q        <= '0;
      mask_q       <= '0;
`endif
    end else begin
      if (d_fire) d_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          a_ready_q <= 1'b1;
          if (a_fire) begin
            a_ready_q    <= 1'b0;
            op_q         <= tl_d_c_a.a_opcode;
            beats_q      <= a_beats;
            iss_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            sticky_err_q <= 1'b0;
            d_size_q     <= tl_d_c_a.a_size;
            d_source_q   <= tl_d_c_a.a_source;
            d_data_q     <= '0;
            d_error_q    <= 1'b0;
            addr_o       <= a_word_addr;
`ifdef TLUH_DEV_ATOMIC_EN
            param_q      <= tl_d_c_a.a_param;
            adata_q      <= tl_d_c_a.a_data;
            mask_q       <= tl_d_c_a.a_mask;
`endif
            if (pre_err) begin
              state_q    <= S_RSP;
              d_valid_q  <= 1'b1;
              d_error_q  <= 1'b1;
              d_opcode_q <= err_opcode;
            end else if (tl_d_c_a.a_opcode == OP_GET) begin
              state_q <= S_RD;
              req_o   <= 1'b1;
              we_o    <= 1'b0;
              be_o    <= '1;
            end else if (tl_d_c_a.a_opcode == OP_PUT_FULL ||
                         tl_d_c_a.a_opcode == OP_PUT_PARTIAL) begin
              // Beat 0 goes straight to memory from channel A.
              state_q <= S_WR;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              wdata_o <= tl_d_c_a.a_data;
              be_o    <= tl_d_c_a.a_mask;
            end else if (tl_d_c_a.a_opcode == OP_INTENT) begin
              state_q    <= S_RSP;
              d_valid_q  <= 1'b1;
              d_opcode_q <= OP_HINT_ACK;
            end else begin
`ifdef TLUH_DEV_ATOMIC_EN
              state_q <= S_AT_RD;
              req_o   <= 1'b1;
              we_o    <= 1'b0;
              be_o    <= '1;
`else
              state_q    <= S_RSP;
              d_valid_q  <= 1'b1;
              d_error_q  <= 1'b1;
              d_opcode_q <= OP_ACCESS_ACK_DATA;
`endif
            end
          end
        end
        S_RD: begin
          if (mem_fire) begin
            req_o      <= 1'b0;
            inflight_q <= 1'b1;
            iss_cnt_q  <= iss_cnt_q + 6'd1;
          end
          if (rvalid_i) begin
            d_valid_q  <= 1'b1;
            d_opcode_q <= OP_ACCESS_ACK_DATA;
            d_data_q   <= rdata_i;
            d_error_q  <= err_i;
            inflight_q <= 1'b0;
          end
          if (d_fire) begin
            rsp_cnt_q <= rsp_cnt_q + 6'd1;
            if (rd_last) begin
              state_q   <= S_IDLE;
              a_ready_q <= 1'b1;
            end
          end
          // Next read only once the D register can take its data.
          if (!req_o && !inflight_q && (iss_cnt_q < beats_q) && (!d_valid_q || d_fire)) begin
            req_o  <= 1'b1;
            addr_o <= addr_o + TL_AW'(TL_DBW);
          end
        end
        S_WR: begin
          if (mem_fire) begin
            req_o        <= 1'b0;
            iss_cnt_q    <= iss_cnt_q + 6'd1;
            sticky_err_q <= sticky_err_q | err_i;
            if (iss_cnt_q == beats_q - 6'd1) begin
              state_q    <= S_RSP;
              we_o       <= 1'b0;
              d_valid_q  <= 1'b1;
              d_opcode_q <= OP_ACCESS_ACK;
              d_error_q  <= sticky_err_q | err_i;
            end else begin
              a_ready_q <= 1'b1;
            end
          end
          if (a_fire) begin
            a_ready_q <= 1'b0;
            req_o     <= 1'b1;
            addr_o    <= addr_o + TL_AW'(TL_DBW);
            wdata_o   <= tl_d_c_a.a_data;
            be_o      <= tl_d_c_a.a_mask;
          end
        end
`ifdef TLUH_DEV_ATOMIC_EN
        S_AT_RD: begin
          if (mem_fire) req_o <= 1'b0;
          if (rvalid_i) begin
            old_q <= rdata_i;
            if (err_i) begin
              state_q    <= S_RSP;
              d_valid_q  <= 1'b1;
              d_opcode_q <= OP_ACCESS_ACK_DATA;
              d_error_q  <= 1'b1;
            end else begin
              state_q <= S_AT_WR;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              wdata_o <= alu_res;
              be_o    <= mask_q;
            end
          end
        end
        S_AT_WR: begin
          if (mem_fire) begin
            req_o      <= 1'b0;
            we_o       <= 1'b0;
            state_q    <= S_RSP;
            d_valid_q  <= 1'b1;
            d_opcode_q <= OP_ACCESS_ACK_DATA;
            d_data_q   <= old_q;
            d_error_q  <= err_i;
          end
        end
`endif
        S_RSP: begin
          if (d_fire) begin
            rsp_cnt_q <= rsp_cnt_q + 6'd1;
            if (rsp_last) begin
              state_q   <= S_IDLE;
              a_ready_q <= 1'b1;
            end else begin
              d_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tl_d_c_d          = '0;
    tl_d_c_d.d_valid  = d_valid_q;
    tl_d_c_d.d_opcode = d_opcode_q;
    tl_d_c_d.d_size   = d_size_q;
    tl_d_c_d.d_source = d_source_q;
    tl_d_c_d.d_data   = d_data_q;
    tl_d_c_d.d_error  = d_error_q;
    tl_d_c_d.a_ready  = a_ready_q;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_tluh_device_adapter.sv
// Directed testbench for tluh_device_adapter with a small behavioural memory.
module tb_tluh_device_adapter;
  import tluh_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  tluh_h2d_t         h2d;
  tluh_d2h_t         d2h;
  logic              req_o, gnt_i, we_o, rvalid_i, err_i;
  logic [TL_AW-1:0]  addr_o;
  logic [TL_DW-1:0]  wdata_o, rdata_i;
  logic [TL_DBW-1:0] be_o;
  logic [2:0]        state_o;

  int checks = 0;
  int errors = 0;

  tluh_device_adapter #(.MAX_SIZE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tl_d_c_a(h2d), .tl_d_c_d(d2h),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .be_o(be_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .err_i(err_i), .state_o(state_o)
  );

  // ---------------- memory model ----------------
  logic        gnt_en = 1'b1;
  int          err_beat = -1;
  int          req_count = 0;
  int          wr_count = 0;
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [3:0]  wr_be_q[$];
  logic [31:0] exp_q[$];

  assign gnt_i = req_o & gnt_en;
  assign err_i = req_o && gnt_i && we_o && (wr_count == err_beat);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_i <= 1'b0;
      rdata_i  <= '0;
    end else begin
      rvalid_i <= 1'b0;
      if (pl_en) mem[pl_idx] <= pl_val;
      if (req_o && gnt_i) begin
        req_count <= req_count + 1;
        if (we_o) begin
          for (int b = 0; b < 4; b++)
            if (be_o[b]) mem[addr_o[7:2]][8*b +: 8] <= wdata_o[8*b +: 8];
          wr_addr_q.push_back(addr_o);
          wr_data_q.push_back(wdata_o);
          wr_be_q.push_back(be_o);
          wr_count <= wr_count + 1;
        end else begin
          rd_addr_q.push_back(addr_o);
          rvalid_i <= 1'b1;
          rdata_i  <= mem[addr_o[7:2]];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk_i);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                        input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk_i);
    h2d.a_valid = 1'b1; h2d.a_opcode = op; h2d.a_param = param; h2d.a_size = size;
    h2d.a_source = src; h2d.a_address = addr; h2d.a_mask = mask; h2d.a_data = data;
    while (!d2h.a_ready && n < 40) begin @(negedge clk_i); n++; end
    checks++;
    if (d2h.a_ready !== 1'b1) begin
      errors++; $display("FAIL a_handshake: a_ready=%0b required 1", d2h.a_ready);
    end
    @(negedge clk_i);
    h2d.a_valid = 1'b0;
  endtask

  task automatic get_beat(input int hold, output tluh_d2h_t beat);
    int n;
    tluh_d2h_t first;
    n = 0;
    while (!d2h.d_valid && n < 40) begin @(negedge clk_i); n++; end
    checks++;
    if (d2h.d_valid !== 1'b1) begin
      errors++; $display("FAIL d_valid_wait: d_valid=%0b required 1", d2h.d_valid);
    end
    first = d2h;
    repeat (hold) @(negedge clk_i);
    if (hold > 0) begin
      checks++;
      if (d2h !== first) begin
        errors++; $display("FAIL d_hold: data=%h required %h", d2h.d_data, first.d_data);
      end
    end
    beat = d2h;
    h2d.d_ready = 1'b1;
    @(negedge clk_i);
    h2d.d_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (d2h.a_ready !== 1'b0 || d2h.d_valid !== 1'b0 || d2h.d_error !== 1'b0 ||
        d2h.d_data !== 32'h0 || req_o !== 1'b0 || we_o !== 1'b0 || addr_o !== 32'h0 ||
        wdata_o !== 32'h0 || be_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: a_ready=%0b d_valid=%0b req=%0b we=%0b addr=%h be=%h required all 0",
               d2h.a_ready, d2h.d_valid, req_o, we_o, addr_o, be_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (d2h.a_ready !== 1'b1 || state_o !== 3'd0) begin
      errors++; $display("FAIL reset_release: a_ready=%0b state=%0d required 1/0", d2h.a_ready, state_o);
    end
  endtask

  task automatic test_get_single();
    tluh_d2h_t b;
    int lat, r0;
    preload(6'h04, 32'hDEADBEEF);
    r0 = req_count;
    send_a(OP_GET, 3'd0, 3'd2, 8'h5A, 32'h10, 4'hF, 32'h0);
    lat = 0;
    while (!d2h.d_valid && lat < 20) begin @(negedge clk_i); lat++; end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL get_latency: %0d required 2", lat); end
    get_beat(0, b);
    checks++;
    if (b.d_data !== 32'hDEADBEEF || b.d_opcode !== OP_ACCESS_ACK_DATA || b.d_source !== 8'h5A ||
        b.d_size !== 3'd2 || b.d_error !== 1'b0) begin
      errors++; $display("FAIL get_single: data=%h op=%0d src=%h err=%0b required deadbeef/1/5a/0",
                         b.d_data, b.d_opcode, b.d_source, b.d_error);
    end
    checks++;
    if (d2h.a_ready !== 1'b1 || d2h.d_valid !== 1'b0 || req_count - r0 != 1) begin
      errors++; $display("FAIL get_single_after: a_ready=%0b d_valid=%0b reqs=%0d required 1/0/1",
                         d2h.a_ready, d2h.d_valid, req_count - r0);
    end
  endtask

  task automatic test_get_burst();
    tluh_d2h_t b;
    int r0;
    logic [31:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      preload(6'(16 + i), 32'hA0A0_0000 + 32'(i));
      exp_q.push_back(32'hA0A0_0000 + 32'(i));
    end
    rd_addr_q.delete();
    r0 = req_count;
    send_a(OP_GET, 3'd0, 3'd4, 8'h03, 32'h40, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      get_beat((i == 1) ? 3 : 0, b);
      exp_v = exp_q.pop_front();
      checks++;
      if (b.d_data !== exp_v || b.d_source !== 8'h03 || b.d_size !== 3'd4 || b.d_error !== 1'b0) begin
        errors++; $display("FAIL burst_beat%0d: data=%h src=%h required %h/03", i, b.d_data, b.d_source, exp_v);
      end
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (req_count - r0 != 4 || d2h.d_valid !== 1'b0 || rd_addr_q.size() != 4) begin
      errors++; $display("FAIL burst_count: reqs=%0d d_valid=%0b required 4/0", req_count - r0, d2h.d_valid);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_addr_q[i] !== 32'h40 + 32'(4 * i)) begin
          errors++; $display("FAIL burst_addr%0d: %h required %h", i, rd_addr_q[i], 32'h40 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_put_partial();
    tluh_d2h_t b;
    preload(6'h02, 32'hFFFFFFFF);
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
    send_a(OP_PUT_PARTIAL, 3'd0, 3'd2, 8'h21, 32'h8, 4'b0011, 32'h1234ABCD);
    get_beat(0, b);
    checks++;
    if (b.d_opcode !== OP_ACCESS_ACK || b.d_error !== 1'b0 || b.d_source !== 8'h21) begin
      errors++; $display("FAIL put_partial_rsp: op=%0d err=%0b src=%h required 0/0/21", b.d_opcode, b.d_error, b.d_source);
    end
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h8 || wr_be_q[0] !== 4'b0011 ||
        wr_data_q[0] !== 32'h1234ABCD || mem[2] !== 32'hFFFFABCD) begin
      errors++; $display("FAIL put_partial_write: writes=%0d mem=%h required 1/ffffabcd", wr_addr_q.size(), mem[2]);
    end
  endtask

  task automatic test_put_burst_err();
    tluh_d2h_t b;
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
    err_beat = wr_count;
    send_a(OP_PUT_FULL, 3'd0, 3'd3, 8'h44, 32'h20, 4'hF, 32'h11111111);
    send_a(OP_PUT_FULL, 3'd0, 3'd3, 8'h44, 32'h24, 4'hF, 32'h22222222);
    get_beat(0, b);
    err_beat = -1;
    checks++;
    if (b.d_opcode !== OP_ACCESS_ACK || b.d_error !== 1'b1 || b.d_size !== 3'd3) begin
      errors++; $display("FAIL put_burst_rsp: op=%0d err=%0b size=%0d required 0/1/3", b.d_opcode, b.d_error, b.d_size);
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'h20 || wr_addr_q[1] !== 32'h24 ||
        mem[8] !== 32'h11111111 || mem[9] !== 32'h22222222) begin
      errors++; $display("FAIL put_burst_writes: writes=%0d mem8=%h mem9=%h required 2/11111111/22222222",
                         wr_addr_q.size(), mem[8], mem[9]);
    end
  endtask

  task automatic test_intent();
    tluh_d2h_t b;
    int r0;
    r0 = req_count;
    send_a(OP_INTENT, 3'd0, 3'd2, 8'h07, 32'h0, 4'hF, 32'h0);
    get_beat(0, b);
    checks++;
    if (b.d_opcode !== OP_HINT_ACK || b.d_error !== 1'b0 || req_count != r0) begin
      errors++; $display("FAIL intent: op=%0d err=%0b reqs=%0d required 2/0/0", b.d_opcode, b.d_error, req_count - r0);
    end
  endtask

  task automatic test_atomic();
    tluh_d2h_t b;
    int r0;
    preload(6'h0C, 32'hFFFFFFFF);
    r0 = req_count;
    send_a(OP_ARITH, 3'd4, 3'd2, 8'h09, 32'h30, 4'hF, 32'h2);
    get_beat(0, b);
    repeat (2) @(negedge clk_i);
    checks++;
`ifdef TLUH_DEV_ATOMIC_EN
    if (b.d_opcode !== OP_ACCESS_ACK_DATA || b.d_error !== 1'b0 || b.d_data !== 32'hFFFFFFFF ||
        mem[12] !== 32'h00000001 || req_count - r0 != 2) begin
      errors++; $display("FAIL atomic_add: data=%h err=%0b mem=%h required ffffffff/0/00000001",
                         b.d_data, b.d_error, mem[12]);
    end
`else
    if (b.d_opcode !== OP_ACCESS_ACK_DATA || b.d_error !== 1'b1 || b.d_data !== 32'h0 ||
        mem[12] !== 32'hFFFFFFFF || req_count != r0) begin
      errors++; $display("FAIL atomic_disabled: op=%0d err=%0b data=%h reqs=%0d required 1/1/0/0",
                         b.d_opcode, b.d_error, b.d_data, req_count - r0);
    end
`endif
  endtask

  task automatic test_size_err();
    tluh_d2h_t b;
    int r0;
    r0 = req_count;
    send_a(OP_GET, 3'd0, 3'd5, 8'h11, 32'h0, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      get_beat(0, b);
      checks++;
      if (b.d_error !== 1'b1 || b.d_data !== 32'h0 || b.d_opcode !== OP_ACCESS_ACK_DATA) begin
        errors++; $display("FAIL size_err_beat%0d: err=%0b data=%h required 1/0", i, b.d_error, b.d_data);
      end
    end
    @(negedge clk_i);
    checks++;
    if (d2h.d_valid !== 1'b0 || req_count != r0) begin
      errors++; $display("FAIL size_err_end: d_valid=%0b reqs=%0d required 0/0", d2h.d_valid, req_count - r0);
    end
  endtask

  task automatic test_misaligned_reset();
    tluh_d2h_t b;
    int r0, seen;
    r0 = req_count;
    send_a(OP_GET, 3'd0, 3'd2, 8'h66, 32'h6, 4'hF, 32'h0);
    get_beat(0, b);
    checks++;
    if (b.d_error !== 1'b1 || b.d_data !== 32'h0 || b.d_source !== 8'h66 || req_count != r0) begin
      errors++; $display("FAIL misaligned: err=%0b data=%h reqs=%0d required 1/0/0", b.d_error, b.d_data, req_count - r0);
    end
    gnt_en = 1'b0;
    send_a(OP_GET, 3'd0, 3'd2, 8'h67, 32'h10, 4'hF, 32'h0);
    @(negedge clk_i);
    checks++;
    if (req_o !== 1'b1 || state_o !== 3'd1) begin
      errors++; $display("FAIL mid_rd: req=%0b state=%0d required 1/1", req_o, state_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (d2h.a_ready !== 1'b0 || d2h.d_valid !== 1'b0 || req_o !== 1'b0 || we_o !== 1'b0 ||
        addr_o !== 32'h0 || be_o !== 4'h0 || state_o !== 3'd0) begin
      errors++; $display("FAIL reset_abort: a_ready=%0b d_valid=%0b req=%0b addr=%h be=%h required all 0",
                         d2h.a_ready, d2h.d_valid, req_o, addr_o, be_o);
    end
    gnt_en = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk_i); if (d2h.d_valid) seen++; end
    checks++;
    if (seen != 0 || req_count != r0 || d2h.a_ready !== 1'b1) begin
      errors++; $display("FAIL after_abort: d_valid_cycles=%0d reqs=%0d a_ready=%0b required 0/0/1",
                         seen, req_count - r0, d2h.a_ready);
    end
  endtask

  task automatic test_back_to_back();
    tluh_d2h_t b;
    preload(6'h05, 32'hCAFE0005);
    send_a(OP_GET, 3'd0, 3'd2, 8'h01, 32'h10, 4'hF, 32'h0);
    get_beat(0, b);
    checks++;
    if (d2h.a_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: a_ready=%0b required 1", d2h.a_ready);
    end
    send_a(OP_GET, 3'd0, 3'd2, 8'h02, 32'h14, 4'hF, 32'h0);
    get_beat(0, b);
    checks++;
    if (b.d_data !== 32'hCAFE0005 || b.d_source !== 8'h02) begin
      errors++; $display("FAIL b2b_second: data=%h src=%h required cafe0005/02", b.d_data, b.d_source);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    h2d = '0;
    test_reset();
    test_get_single();
    test_get_burst();
    test_put_partial();
    test_put_burst_err();
    test_intent();
    test_atomic();
    test_size_err();
    test_misaligned_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
